// File: rtl/matrix_slot_store_pkg.sv
// matrix_slot_store_pkg: shared constants, slot metadata record and FSM encodings
package matrix_slot_store_pkg;
   localparam int SLOT_WORDS = 25;
   localparam int MAX_DIM = 5;
   localparam int ID_W = 8;
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic [2:0]      m;
      logic [2:0]      n;
   } meta_t;
   typedef enum logic {W_IDLE, W_FILL} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_LOOKUP, R_STREAM} r_state_t;
endpackage

// File: rtl/matrix_slot_ram.sv
// matrix_slot_ram: simple dual-port storage, one write port and one registered read port
module matrix_slot_ram #(
   parameter int DEPTH = 200,
   parameter int DATA_W = 32,
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/matrix_slot_store.sv
// matrix_slot_store: ring of fixed-size matrix slots with ID-based commit and streaming read-back
module matrix_slot_store
   import matrix_slot_store_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_enable,
   input  logic              alloc_req,
   input  logic [2:0]        dim_m,
   input  logic [2:0]        dim_n,
   output logic [ADDR_W-1:0] base_addr,
   output logic              addr_ready,
   output logic              alloc_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fill_done,
   output logic              wr_oob,
   output logic              commit_valid,
   output logic [ID_W-1:0]   commit_id,
   output logic [3:0]        slot_count,
   input  logic              rd_req,
   input  logic [ID_W-1:0]   rd_id,
   output logic              rd_busy,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic [2:0]        rd_m,
   output logic [2:0]        rd_n,
   output logic              rd_miss
);
   localparam int PW = $clog2(NUM_SLOTS);
   localparam int DEPTH = NUM_SLOTS * SLOT_WORDS;
   localparam int RAW = $clog2(DEPTH);

   function automatic logic [ADDR_W-1:0] slot_base(input logic [PW-1:0] s);
      return ADDR_W'(s) * ADDR_W'(SLOT_WORDS);
   endfunction

   w_state_t          w_state;
   r_state_t          r_state;
   meta_t             meta [NUM_SLOTS];
   logic [PW-1:0]     wr_ptr, ptr_inc, grant_ptr, hit_slot;
   logic [ID_W-1:0]   next_id, rd_id_q;
   logic [2:0]        m_q, n_q;
   logic [5:0]        len_q, hit_len, rd_len_q, rd_cnt;
   logic [ADDR_W-1:0] rd_base_q;
   logic [RAW-1:0]    ram_raddr;
   logic              fill_st, commit, dims_ok, in_win, ram_we, ram_re, hit;

   assign fill_st = w_state == W_FILL;
   assign commit = wr_enable && fill_st && (fill_done || alloc_req);
   assign ptr_inc = (wr_ptr == PW'(NUM_SLOTS - 1)) ? '0 : wr_ptr + 1'b1;
   assign grant_ptr = commit ? ptr_inc : wr_ptr;
   assign dims_ok = dim_m >= 3'd1 && dim_m <= 3'(MAX_DIM) && dim_n >= 3'd1 && dim_n <= 3'(MAX_DIM);
   assign in_win = wr_addr >= base_addr && {1'b0, wr_addr} < {1'b0, base_addr} + (ADDR_W+1)'(len_q);
   assign ram_we = wr_enable && fill_st && wr_en && in_win;

   // The slot being granted is invalidated immediately so reads can never target the open slot.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_state <= W_IDLE;
         for (int i = 0; i < NUM_SLOTS; i++) meta[i] <= '0;
         wr_ptr <= '0;
         next_id <= ID_W'(1);
         m_q <= '0;
         n_q <= '0;
         len_q <= '0;
         base_addr <= '0;
         addr_ready <= 1'b0;
         alloc_err <= 1'b0;
         wr_oob <= 1'b0;
         commit_valid <= 1'b0;
         commit_id <= '0;
      end else begin
         addr_ready <= 1'b0;
         alloc_err <= 1'b0;
         wr_oob <= 1'b0;
         commit_valid <= 1'b0;
         if (!wr_enable) w_state <= W_IDLE;
         else begin
            if (fill_st && wr_en && !in_win) wr_oob <= 1'b1;
            if (commit) begin
               meta[wr_ptr] <= {1'b1, next_id, m_q, n_q};
               commit_valid <= 1'b1;
               commit_id <= next_id;
               next_id <= (next_id == '1) ? ID_W'(1) : next_id + 1'b1;
               wr_ptr <= ptr_inc;
               w_state <= W_IDLE;
            end
            if (alloc_req) begin
               if (dims_ok) begin
                  meta[grant_ptr].valid <= 1'b0;
                  m_q <= dim_m;
                  n_q <= dim_n;
                  len_q <= 6'(dim_m) * 6'(dim_n);
                  base_addr <= slot_base(grant_ptr);
                  addr_ready <= 1'b1;
                  w_state <= W_FILL;
               end else begin
                  alloc_err <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
         end
      end

   always_comb begin
      slot_count = '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_count = slot_count + 4'(meta[i].valid);
   end

   always_comb begin
      hit = 1'b0;
      hit_slot = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (meta[i].valid && meta[i].id == rd_id_q) begin
            hit = 1'b1;
            hit_slot = PW'(i);
         end
   end

   assign hit_len = 6'(meta[hit_slot].m) * 6'(meta[hit_slot].n);
   assign rd_busy = r_state != R_IDLE;
   // The first word is fetched during lookup so the first beat lands two cycles after the request.
   assign ram_re = (r_state == R_LOOKUP && hit) || (r_state == R_STREAM && !rd_last);
   assign ram_raddr = RAW'((r_state == R_LOOKUP) ? slot_base(hit_slot) : rd_base_q + ADDR_W'(rd_cnt));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= R_IDLE;
         rd_id_q <= '0;
         rd_miss <= 1'b0;
         rd_valid <= 1'b0;
         rd_last <= 1'b0;
         rd_m <= '0;
         rd_n <= '0;
         rd_len_q <= '0;
         rd_base_q <= '0;
         rd_cnt <= '0;
      end else begin
         rd_miss <= 1'b0;
         case (r_state)
            R_IDLE:
               if (rd_req) begin
                  rd_id_q <= rd_id;
                  if (rd_id != '0) r_state <= R_LOOKUP;
                  else rd_miss <= 1'b1;
               end
            R_LOOKUP:
               if (!hit) begin
                  rd_miss <= 1'b1;
                  r_state <= R_IDLE;
               end else begin
                  rd_m <= meta[hit_slot].m;
                  rd_n <= meta[hit_slot].n;
                  rd_len_q <= hit_len;
                  rd_base_q <= slot_base(hit_slot);
                  rd_cnt <= 6'd1;
                  rd_valid <= 1'b1;
                  rd_last <= hit_len == 6'd1;
                  r_state <= R_STREAM;
               end
            R_STREAM:
               if (rd_last) begin
                  rd_valid <= 1'b0;
                  rd_last <= 1'b0;
                  r_state <= R_IDLE;
               end else begin
                  rd_last <= rd_cnt == rd_len_q - 1'b1;
                  rd_cnt <= rd_cnt + 1'b1;
               end
            default: r_state <= R_IDLE;
         endcase
      end

   matrix_slot_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(RAW)) u_ram (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (ram_we),
      .waddr(RAW'(wr_addr)),
      .wdata(wr_data),
      .re   (ram_re),
      .raddr(ram_raddr),
      .rdata(rd_data)
   );
endmodule
